// File: rtl/gpio_input_conditioner_if.sv
// Pin-side bundle for the GPIO input conditioner: raw pad levels in,
// debounced level and edge pulses out.
interface gpio_input_conditioner_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] io_pins_raw;
    logic [WIDTH-1:0] io_pins_clean;
    logic [WIDTH-1:0] io_rise;
    logic [WIDTH-1:0] io_fall;
    logic             io_change;

    modport master (
        output io_pins_raw,
        input  io_pins_clean,
        input  io_rise,
        input  io_fall,
        input  io_change
    );

    modport slave (
        input  io_pins_raw,
        output io_pins_clean,
        output io_rise,
        output io_fall,
        output io_change
    );
endinterface

// File: rtl/gpio_input_conditioner.sv
// Per-pin synchronizer plus stability-counter debouncer producing a clean level
// and registered one-cycle rise/fall pulses.
module gpio_input_conditioner #(
    parameter int unsigned     WIDTH           = 4,
    parameter int unsigned     SYNC_STAGES     = 2,
    parameter int unsigned     DEBOUNCE_CYCLES = 65536,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
    input logic                       io_clock,
    input logic                       io_reset,
    gpio_input_conditioner_if.slave   pins
);
    // A 1-cycle debounce still needs a 1-bit counter so the vector is never zero-width.
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CntW-1:0]  cnt_q  [WIDTH];
    logic [CntW-1:0]  cnt_d  [WIDTH];
    logic [WIDTH-1:0] clean_q, clean_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             change_q, change_d;
    logic [WIDTH-1:0] sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= pins.io_pins_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            // Any return to the clean level drops the count: no partial credit.
            if (sync[i] != clean_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    clean_d[i] = sync[i];
                    rise_d[i]  = sync[i];
                    fall_d[i]  = ~sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
        change_d = |{rise_d, fall_d};
    end

    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            clean_q  <= RESET_VALUE;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            clean_q  <= clean_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
        end
    end

    assign pins.io_pins_clean = clean_q;
    assign pins.io_rise       = rise_q;
    assign pins.io_fall       = fall_q;
    assign pins.io_change     = change_q;
endmodule
